// File: rtl/ptp_rx_parser.sv
// PTP event receive parser: walks a GMII receive stream, timestamps the SFD,
// validates the PTP-over-Ethernet header and presents one record per good
// frame through a valid/ready handshake with a saturating overflow counter.
module ptp_rx_parser #(
  parameter int TS_W = 64
) (
  input  logic            clk,
  input  logic            arst,
  input  logic [7:0]      gmii_rxd,
  input  logic            gmii_rx_dv,
  input  logic            gmii_rx_er,
  input  logic [TS_W-1:0] timer_i,
  output logic            msg_valid_o,
  input  logic            msg_ready_i,
  output logic [3:0]      msg_type_o,
  output logic [15:0]     seq_id_o,
  output logic [TS_W-1:0] ts_o,
  output logic [15:0]     drop_cnt_o
);

  typedef enum logic [1:0] {IDLE, PREAMBLE, HDR, DROP} state_t;

  localparam logic [5:0] LAST_CNT = 6'd46;

  state_t          state;
  logic [5:0]      byte_cnt;
  logic [3:0]      p_type;
  logic [15:0]     p_seq;
  logic [TS_W-1:0] p_ts;
  logic            frame_done;

  // A frame completes only when dv drops after every captured header byte.
  assign frame_done = (state == HDR) && !gmii_rx_dv && (byte_cnt == LAST_CNT);

  // Receive-side state machine and pending-record capture.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state    <= IDLE;
      byte_cnt <= '0;
      p_type   <= '0;
      p_seq    <= '0;
      p_ts     <= '0;
    end else if (gmii_rx_dv && gmii_rx_er) begin
      // A coding error poisons the whole frame, whatever state we are in.
      state  <= DROP;
      p_type <= '0;
      p_seq  <= '0;
      p_ts   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gmii_rx_dv) state <= (gmii_rxd == 8'h55) ? PREAMBLE : DROP;
        end
        PREAMBLE: begin
          if (!gmii_rx_dv) begin
            state <= IDLE;
          end else if (gmii_rxd == 8'hD5) begin
            p_ts     <= timer_i;
            byte_cnt <= '0;
            state    <= HDR;
          end else if (gmii_rxd != 8'h55) begin
            state <= DROP;
          end
        end
        HDR: begin
          if (!gmii_rx_dv) begin
            // Either a completed frame (record handled below) or a runt.
            state <= IDLE;
          end else begin
            if (byte_cnt != LAST_CNT) byte_cnt <= byte_cnt + 6'd1;
            case (byte_cnt)
              6'd12: if (gmii_rxd != 8'h88) state <= DROP;
              6'd13: if (gmii_rxd != 8'hF7) state <= DROP;
              6'd14: p_type <= gmii_rxd[3:0];
              6'd15: if (gmii_rxd[3:0] != 4'h2) state <= DROP;
              6'd44: p_seq[15:8] <= gmii_rxd;
              6'd45: p_seq[7:0]  <= gmii_rxd;
              default: ;
            endcase
          end
        end
        DROP: begin
          if (!gmii_rx_dv) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output record register: a held record is never overwritten; a record that
  // finds the slot busy is counted as dropped.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      msg_valid_o <= 1'b0;
      msg_type_o  <= '0;
      seq_id_o    <= '0;
      ts_o        <= '0;
      drop_cnt_o  <= '0;
    end else if (frame_done) begin
      if (!msg_valid_o || msg_ready_i) begin
        msg_valid_o <= 1'b1;
        msg_type_o  <= p_type;
        seq_id_o    <= p_seq;
        ts_o        <= p_ts;
      end else if (drop_cnt_o != 16'hFFFF) begin
        drop_cnt_o <= drop_cnt_o + 16'd1;
      end
    end else if (msg_valid_o && msg_ready_i) begin
      msg_valid_o <= 1'b0;
    end
  end

endmodule

// File: doc/ptp_rx_parser.md
PTP_RX_PARSER -- requirements
Module: ptp_rx_parser

Interface
REQ-001 SHALL have parameter TS_W, default 64: width of the timer_i sample and the ts_o field.
REQ-002 SHALL have port clk, input, 1: single clock, equal to the GMII RX clock domain; all logic on the rising edge.
REQ-003 SHALL have port arst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port gmii_rxd, input, 8: GMII receive data.
REQ-005 SHALL have port gmii_rx_dv, input, 1: GMII receive data valid.
REQ-006 SHALL have port gmii_rx_er, input, 1: GMII receive error.
REQ-007 SHALL have port timer_i, input, TS_W: free-running local time, sampled at the SFD.
REQ-008 SHALL have port msg_valid_o, output, 1: a parsed PTP event record is available.
REQ-009 SHALL have port msg_ready_i, input, 1: the consumer accepts the record.
REQ-010 SHALL have port msg_type_o, output, 4: PTP messageType.
REQ-011 SHALL have port seq_id_o, output, 16: PTP sequenceId.
REQ-012 SHALL have port ts_o, output, TS_W: timer_i value sampled at the SFD.
REQ-013 SHALL have port drop_cnt_o, output, 16: count of records lost to back-pressure; saturating.

Function
REQ-014 SHALL implement the states IDLE, PREAMBLE, HDR and DROP.
REQ-015 IDLE: on dv=1 with rxd=0x55, go to PREAMBLE; on dv=1 with any other byte, go to DROP.
REQ-016 PREAMBLE: rxd=0x55 stays in PREAMBLE.
REQ-017 PREAMBLE: rxd=0xD5 latches timer_i into the pending timestamp, clears the byte counter and goes to HDR.
REQ-018 PREAMBLE: any other byte goes to DROP.
REQ-019 HDR: each dv=1 cycle increments a 6-bit byte counter (first byte after the SFD is index 0); the counter saturates at 46.
REQ-020 HDR SHALL capture the bytes at these indices:
- 12: ethertype high byte; SHALL be 0x88.
- 13: ethertype low byte; SHALL be 0xF7.
- 14: bits[3:0] become the pending msg_type.
- 15: bits[3:0] (versionPTP) SHALL be 0x2.
- 44: becomes seq_id[15:8].
- 45: becomes seq_id[7:0].
REQ-021 A mismatch at index 12, 13 or 15 SHALL go to DROP.
REQ-022 gmii_rx_er=1 while dv=1, in any state, SHALL go to DROP and discard the pending record.
REQ-023 DROP: ignore all bytes; return to IDLE on the first cycle with dv=0.
REQ-024 HDR with dv=0 and counter < 46: discard and return to IDLE.
REQ-025 HDR with dv=0 and counter = 46: the frame completes and the state returns to IDLE.
- Padding and FCS bytes beyond index 45 are ignored.
- The FCS is not checked.
REQ-026 On frame completion, if msg_valid_o=0 or msg_ready_i=1 in that same cycle:
- load msg_type_o, seq_id_o and ts_o;
- assert msg_valid_o on the next cycle.
REQ-027 On frame completion with msg_valid_o=1 and msg_ready_i=0:
- discard the new record and keep the held record unchanged;
- increment drop_cnt_o, saturating at 0xFFFF.
REQ-028 Handshake: msg_valid_o SHALL stay high and the output fields SHALL stay stable until a cycle with msg_ready_i=1.
- A transfer with no simultaneous completion deasserts msg_valid_o next cycle.
REQ-029 Latency: msg_valid_o SHALL rise 1 clk after the first dv=0 cycle of an accepted frame.
REQ-030 A new frame may begin in the cycle after dv falls; parsing SHALL NOT depend on the output handshake state.

Reset
REQ-031 While arst=1:
- state=IDLE;
- byte counter=0;
- msg_valid_o=0;
- msg_type_o=0, seq_id_o=0, ts_o=0;
- drop_cnt_o=0;
- the pending record is cleared.
REQ-032 arst asserted mid-frame SHALL abort the frame with no record emitted.
REQ-033 After release, a frame already in progress (dv=1 at release) SHALL be treated as a bad start: IDLE goes to DROP unless the byte is 0x55.

Verification
REQ-034 Valid frame: 7x0x55, 0xD5 with timer_i=0x1234; ethertype 0x88F7; byte14=0x00; byte15=0x02; seq 0xABCD; 60 bytes then dv=0; ready=1.
- Response: one record, type=0, seq=0xABCD, ts=0x1234.
REQ-035 Wrong ethertype (0x0800) -> no msg_valid_o; drop_cnt_o unchanged.
REQ-036 gmii_rx_er pulse at index 30 of an otherwise valid frame -> no record.
- An identical next frame SHALL then produce a record.
REQ-037 Two valid frames, seq 1 then 2, with ready=0 throughout:
- record seq=1 is held;
- drop_cnt_o=1;
- raising ready then transfers seq=1 only.
REQ-038 Held record seq=1 with ready=1 in the exact cycle frame seq=2 completes -> seq=1 transferred, seq=2 loaded, drop_cnt_o=0.
REQ-039 Truncated frame with dv=0 after index 40 -> no record; state returns to IDLE.
REQ-040 arst pulse at index 20 -> all outputs zero; no record.
- The following valid frame SHALL parse normally.
